gcd_binary_core: RTL and testbench

GCD_BINARY_CORE -- requirements
Module: gcd_binary_core

---
 rtl/sobel_gcd_pkg.sv | 15 +
 rtl/gcd_binary_core.sv | 131 +++++++++++++
 tb/tb_gcd_binary_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_gcd_pkg.sv
// Shared types and default sizing for the binary GCD engine.
package sobel_gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 16;
  localparam int unsigned GCD_CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STRIP = 3'd1,
    ST_ODD   = 3'd2,
    ST_LOOP  = 3'd3,
    ST_DONE  = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_binary_core.sv
// Binary (Stein) GCD engine: one shift/compare/subtract step per clock,
// valid/ready on both sides, abort and saturating cycle count.
module gcd_binary_core
  import sobel_gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF,
  parameter int unsigned CNT_W = GCD_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             abort_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic             zero_o,
  output logic [CNT_W-1:0] cycles_o
);

  // k counts common factors of two; it never exceeds WIDTH-1.
  localparam int unsigned K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gcd_state_e       r_state;
  gcd_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             w_accept;
  logic             w_opnd_zero;
  logic             w_busy;

  assign w_accept    = (r_state == ST_IDLE) && in_valid_i;
  assign w_opnd_zero = (operand_a_i == '0) || (operand_b_i == '0);
  assign w_busy      = (r_state == ST_STRIP) || (r_state == ST_ODD) || (r_state == ST_LOOP);

  // State register
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic; abort outranks every busy-state transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_opnd_zero ? ST_DONE : ST_STRIP;
      ST_STRIP: if (abort_i) w_state_nxt = ST_IDLE;
                else if (r_a[0] || r_b[0]) w_state_nxt = ST_ODD;
      ST_ODD:   if (abort_i) w_state_nxt = ST_IDLE;
                else if (r_a[0]) w_state_nxt = ST_LOOP;
      ST_LOOP:  if (abort_i) w_state_nxt = ST_IDLE;
                else if (r_b == '0) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: in_ready_o  = 1'b1;
      ST_DONE: out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands, shift count, result and cycle counter
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      r_gcd  <= '0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_busy && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_a    <= operand_a_i;
            r_b    <= operand_b_i;
            r_k    <= '0;
            r_cnt  <= '0;
            r_zero <= (operand_a_i == '0) && (operand_b_i == '0);
            if (w_opnd_zero) r_gcd <= operand_a_i | operand_b_i;
          end
        end
        ST_STRIP: begin
          if (!abort_i && !r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + K_W'(1);
          end
        end
        ST_ODD: begin
          if (!abort_i && !r_a[0]) r_a <= r_a >> 1;
        end
        ST_LOOP: begin
          // a stays odd here; the restored factor 2^k always fits in WIDTH
          if (!abort_i) begin
            if (r_b == '0) begin
              r_gcd <= r_a << r_k;
            end else if (!r_b[0]) begin
              r_b <= r_b >> 1;
            end else if (r_a > r_b) begin
              r_a <= r_b;
              r_b <= r_a;
            end else begin
              r_b <= r_b - r_a;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gcd_o    = r_gcd;
  assign zero_o   = r_zero;
  assign cycles_o = r_cnt;

endmodule

// File: tb/tb_gcd_binary_core.sv
// Bench for gcd_binary_core: directed scenarios plus random sweeps at
// WIDTH=16 and WIDTH=8 against a Euclid-based reference.
module tb_gcd_binary_core;
  import sobel_gcd_pkg::*;

  localparam int N_RAND = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        abort;
  logic        out_ready;
  logic        sel;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        rdy16, vld16, zero16;
  logic [15:0] gcd16;
  logic [7:0]  cyc16;
  logic        rdy8, vld8, zero8;
  logic [7:0]  gcd8;
  logic [7:0]  cyc8;

  logic        m_rdy, m_vld, m_zero;
  logic [31:0] m_gcd, m_cyc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gcd_binary_core #(.WIDTH(16), .CNT_W(8)) u_dut16 (
    .clk_i(clk), .nreset_i(rst_n),
    .in_valid_i(in_valid && !sel), .in_ready_o(rdy16),
    .operand_a_i(op_a[15:0]), .operand_b_i(op_b[15:0]),
    .abort_i(abort && !sel),
    .out_valid_o(vld16), .out_ready_i(out_ready),
    .gcd_o(gcd16), .zero_o(zero16), .cycles_o(cyc16)
  );

  gcd_binary_core #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk_i(clk), .nreset_i(rst_n),
    .in_valid_i(in_valid && sel), .in_ready_o(rdy8),
    .operand_a_i(op_a[7:0]), .operand_b_i(op_b[7:0]),
    .abort_i(abort && sel),
    .out_valid_o(vld8), .out_ready_i(out_ready),
    .gcd_o(gcd8), .zero_o(zero8), .cycles_o(cyc8)
  );

  assign m_rdy  = sel ? rdy8  : rdy16;
  assign m_vld  = sel ? vld8  : vld16;
  assign m_zero = sel ? zero8 : zero16;
  assign m_gcd  = sel ? 32'(gcd8) : 32'(gcd16);
  assign m_cyc  = sel ? 32'(cyc8) : 32'(cyc16);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference GCD by Euclid's remainder method; gcd(x,0)=x, gcd(0,0)=0
  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // One full transaction; out_ready is held low for 'hold' cycles after DONE.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input int hold,
                        output int lat, output logic [31:0] cyc);
    logic [31:0] exp_g;
    logic        exp_z;
    int          lim;
    exp_g = ref_gcd(oa, ob);
    exp_z = (oa == 0) && (ob == 0);
    lim   = sel ? (8 * 8 + 4) : (8 * 16 + 4);
    check("accept_ready", m_rdy, 1);
    op_a = oa; op_b = ob; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    check("busy_not_ready", m_rdy, 0);
    lat = 0;
    while (!m_vld && lat < lim + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("reached_done", m_vld, 1);
    check("gcd", m_gcd, exp_g);
    check("zero", m_zero, exp_z);
    check("cycles_eq_latency", m_cyc, lat);
    check("latency_bound", (lat <= lim), 1);
    cyc = m_cyc;
    for (int i = 0; i < hold; i++) begin
      op_a = 5; op_b = 10; in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", m_vld, 1);
      check("hold_gcd", m_gcd, exp_g);
      check("hold_cycles", m_cyc, cyc);
      check("hold_blocked", m_rdy, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_handshake_valid", m_vld, 0);
    check("post_handshake_gcd", m_gcd, exp_g);
  endtask

  initial begin
    int          lat;
    logic [31:0] cyc, ra, rb, mask;
    int          sh;

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    sel = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", m_rdy, 1);
    check("rst_valid", m_vld, 0);
    check("rst_gcd", m_gcd, 0);
    check("rst_zero", m_zero, 0);
    check("rst_cycles", m_cyc, 0);
    check("rst_ready8", rdy8, 1);
    @(negedge clk); rst_n = 1'b1;

    run_op(48, 18, 0, lat, cyc);
    run_op(0, 7, 0, lat, cyc);
    check("zero_op_latency", lat, 0);
    check("zero_op_cycles", cyc, 0);
    run_op(0, 0, 0, lat, cyc);
    run_op(65535, 65535, 0, lat, cyc);
    run_op(1024, 4096, 0, lat, cyc);
    run_op(1071, 462, 10, lat, cyc);

    // Abort three cycles into a long operation
    op_a = 40000; op_b = 3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_to_idle", m_rdy, 1);
    check("abort_no_valid", m_vld, 0);
    check("abort_keeps_gcd", m_gcd, 21);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_quiet", m_vld, 0);
    run_op(9, 6, 0, lat, cyc);

    // Reset while deep in LOOP
    op_a = 40000; op_b = 3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("pre_reset_busy", m_rdy, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", m_rdy, 1);
    check("midrst_valid", m_vld, 0);
    check("midrst_gcd", m_gcd, 0);
    check("midrst_zero", m_zero, 0);
    check("midrst_cycles", m_cyc, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(12, 18, 0, lat, cyc);

    // Random sweeps at both widths
    for (int s = 0; s < 2; s++) begin
      sel  = (s == 1);
      mask = sel ? 32'h0000_00FF : 32'h0000_FFFF;
      for (int n = 0; n < N_RAND; n++) begin
        ra = $urandom;
        rb = $urandom;
        sh = int'($urandom_range(0, sel ? 7 : 15));
        case ($urandom_range(0, 7))
          0: ra = 0;
          1: rb = 0;
          2: begin ra = (ra & 32'h3F) << sh; rb = (rb & 32'h1F) << sh; end
          3: rb = ra;
          4: begin ra = ra & 32'h7; rb = rb & 32'h7; end
          default: ;
        endcase
        run_op(ra & mask, rb & mask, 0, lat, cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
